// File: rtl/sd_spi_pkg.sv
// Shared constants and state encoding for the SPI-mode SD engines.
// Imported by the sector reader and its byte shifter.
package sd_spi_pkg;

    localparam logic [7:0]  CMD17_BYTE     = 8'h51;
    localparam logic [7:0]  DATA_TOKEN     = 8'hFE;
    localparam logic [7:0]  DUMMY_BYTE     = 8'hFF;
    localparam int unsigned SD_BLOCK_BYTES = 512;

    typedef enum logic [8:0] {
        StIdle      = 9'b0_0000_0001,
        StSendCmd   = 9'b0_0000_0010,
        StWaitR1    = 9'b0_0000_0100,
        StWaitToken = 9'b0_0000_1000,
        StRxData    = 9'b0_0001_0000,
        StRxCrc     = 9'b0_0010_0000,
        StErr       = 9'b0_0100_0000,
        StTail      = 9'b0_1000_0000,
        StDone      = 9'b1_0000_0000
    } rd_state_e;

endpackage

// File: rtl/sd_spi_byte.sv
// Full-duplex SPI mode-0 byte shifter, MSB first, with a CLK_DIV clock divider.
// sd_clk idles low between bytes; MOSI returns high once a byte completes.
module sd_spi_byte #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] tx_byte,
    input  logic       miso,
    output logic       done,
    output logic [7:0] rx_byte,
    output logic       sd_clk,
    output logic       sd_mosi
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          busy_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic          sclk_q;
    logic          mosi_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic          done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            div_q  <= '0;
            bit_q  <= '0;
            sclk_q <= 1'b0;
            mosi_q <= 1'b1;
            tx_q   <= '0;
            rx_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!busy_q) begin
                if (start) begin
                    busy_q <= 1'b1;
                    div_q  <= '0;
                    bit_q  <= '0;
                    // First bit is presented before the first rising edge.
                    mosi_q <= tx_byte[7];
                    tx_q   <= {tx_byte[6:0], 1'b0};
                end
            end else if (div_q == DW'(CLK_DIV - 1)) begin
                div_q  <= '0;
                sclk_q <= ~sclk_q;
                if (!sclk_q) begin
                    rx_q <= {rx_q[6:0], miso};
                end else if (bit_q == 3'd7) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    mosi_q <= 1'b1;
                end else begin
                    bit_q  <= bit_q + 3'd1;
                    mosi_q <= tx_q[7];
                    tx_q   <= {tx_q[6:0], 1'b0};
                end
            end else begin
                div_q <= div_q + DW'(1);
            end
        end
    end

    assign done    = done_q;
    assign rx_byte = rx_q;
    assign sd_clk  = sclk_q;
    assign sd_mosi = mosi_q;

endmodule

// File: rtl/sd_sec_reader.sv
// SPI-mode SD single-block read engine: issues CMD17, waits for R1 and the
// start token, then streams the 512-byte sector out as 256 16-bit words.
module sd_sec_reader
    import sd_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 2,
    parameter int unsigned RESP_TIMEOUT  = 64,
    parameter int unsigned TOKEN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sd_init_done,
    input  logic        rd_start_en,
    input  logic [31:0] rd_sec_addr,
    output logic        rd_busy,
    output logic        rd_val_en,
    output logic [15:0] rd_val_data,
    output logic        rd_err,
    input  logic        sd_miso,
    output logic        sd_clk,
    output logic        sd_cs,
    output logic        sd_mosi
);

    localparam int unsigned POLL_MAX = (RESP_TIMEOUT > TOKEN_TIMEOUT) ? RESP_TIMEOUT
                                                                       : TOKEN_TIMEOUT;
    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    rd_state_e   state_q, state_d;
    logic        start_q;
    logic [31:0] addr_q, addr_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [7:0]  hi_q, hi_d;
    logic        kick_q, kick_d;
    logic        val_q, val_d;
    logic [15:0] vdata_q, vdata_d;

    logic        spi_done;
    logic [7:0]  spi_rx;
    logic [7:0]  tx_byte;
    logic        accept;

    assign accept = (state_q == StIdle) && sd_init_done && rd_start_en && !start_q;

    sd_spi_byte #(
        .CLK_DIV (CLK_DIV)
    ) u_byte (
        .clk     (clk),
        .rst     (rst),
        .start   (kick_q),
        .tx_byte (tx_byte),
        .miso    (sd_miso),
        .done    (spi_done),
        .rx_byte (spi_rx),
        .sd_clk  (sd_clk),
        .sd_mosi (sd_mosi)
    );

    always_comb begin
        tx_byte = DUMMY_BYTE;
        if (state_q == StSendCmd) begin
            case (byte_cnt_q[2:0])
                3'd0:    tx_byte = CMD17_BYTE;
                3'd1:    tx_byte = addr_q[31:24];
                3'd2:    tx_byte = addr_q[23:16];
                3'd3:    tx_byte = addr_q[15:8];
                3'd4:    tx_byte = addr_q[7:0];
                default: tx_byte = DUMMY_BYTE;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        byte_cnt_d = byte_cnt_q;
        poll_d     = poll_q;
        hi_d       = hi_q;
        kick_d     = 1'b0;
        val_d      = 1'b0;
        vdata_d    = vdata_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d    = StSendCmd;
                    addr_d     = rd_sec_addr;
                    byte_cnt_d = '0;
                    kick_d     = 1'b1;
                end
            end
            StSendCmd: begin
                if (spi_done) begin
                    kick_d = 1'b1;
                    if (byte_cnt_q == 10'd5) begin
                        state_d = StWaitR1;
                        poll_d  = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end
            end
            StWaitR1: begin
                if (spi_done) begin
                    if (spi_rx == 8'h00) begin
                        state_d = StWaitToken;
                        poll_d  = '0;
                        kick_d  = 1'b1;
                    end else if (spi_rx != DUMMY_BYTE || poll_q == PW'(RESP_TIMEOUT - 1)) begin
                        state_d = StErr;
                    end else begin
                        poll_d = poll_q + PW'(1);
                        kick_d = 1'b1;
                    end
                end
            end
            StWaitToken: begin
                if (spi_done) begin
                    if (spi_rx == DATA_TOKEN) begin
                        state_d    = StRxData;
                        byte_cnt_d = '0;
                        kick_d     = 1'b1;
                    end else if (spi_rx != DUMMY_BYTE || poll_q == PW'(TOKEN_TIMEOUT - 1)) begin
                        state_d = StErr;
                    end else begin
                        poll_d = poll_q + PW'(1);
                        kick_d = 1'b1;
                    end
                end
            end
            StRxData: begin
                if (spi_done) begin
                    kick_d = 1'b1;
                    if (!byte_cnt_q[0]) begin
                        hi_d = spi_rx;
                    end else begin
                        val_d   = 1'b1;
                        vdata_d = {hi_q, spi_rx};
                    end
                    if (byte_cnt_q == 10'(SD_BLOCK_BYTES - 1)) begin
                        state_d    = StRxCrc;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end
            end
            StRxCrc: begin
                if (spi_done) begin
                    kick_d = 1'b1;
                    if (byte_cnt_q == 10'd1) begin
                        state_d = StTail;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 10'd1;
                    end
                end
            end
            StErr: begin
                state_d = StTail;
                kick_d  = 1'b1;
            end
            // One dummy byte with CS high gives the card its 8 trailing clocks.
            StTail: begin
                if (spi_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            addr_q     <= '0;
            byte_cnt_q <= '0;
            poll_q     <= '0;
            hi_q       <= '0;
            kick_q     <= 1'b0;
            val_q      <= 1'b0;
            vdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= rd_start_en;
            addr_q     <= addr_d;
            byte_cnt_q <= byte_cnt_d;
            poll_q     <= poll_d;
            hi_q       <= hi_d;
            kick_q     <= kick_d;
            val_q      <= val_d;
            vdata_q    <= vdata_d;
        end
    end

    assign rd_busy     = !((state_q == StIdle) || (state_q == StDone));
    assign sd_cs       = (state_q == StIdle) || (state_q == StTail) || (state_q == StDone);
    assign rd_err      = (state_q == StErr);
    assign rd_val_en   = val_q;
    assign rd_val_data = vdata_q;

endmodule
